// File: rtl/thumb_fetch_align.sv
`default_nettype none
// ============================================================================
// Module   : thumb_fetch_align
// Purpose  : Splits 32-bit fetch words into left-justified 16/32-bit Thumb
//            instructions through a 4-halfword queue, with redirect realign.
// Revision : 1.0 - initial release
// ============================================================================
module thumb_fetch_align (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fw_data,
  input  logic        fw_valid,
  output logic        fw_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] inst_out,
  output logic        inst_is32,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready
);

  logic [15:0] r_q [4];
  logic [1:0]  r_rd_ptr;
  logic [1:0]  r_wr_ptr;
  logic [2:0]  r_count;
  logic        r_drop_first;
  logic [31:0] r_pc;

  logic [15:0] w_head;
  logic [15:0] w_second;
  logic        w_head_is32;
  logic        w_enq;
  logic        w_deq;
  logic [2:0]  w_enq_n;
  logic [2:0]  w_deq_n;
  logic        w_unused;

  assign w_unused = flush_pc[0];

  assign w_head      = r_q[r_rd_ptr];
  assign w_second    = r_q[r_rd_ptr + 2'd1];
  // First halfword of a 32-bit encoding: bits [15:11] = 11101/11110/11111
  assign w_head_is32 = (w_head[15:13] == 3'b111) && (w_head[12:11] != 2'b00);

  assign inst_valid = w_head_is32 ? (r_count >= 3'd2) : (r_count != 3'd0);
  assign inst_is32  = w_head_is32;
  assign inst_out   = w_head_is32 ? {w_head, w_second} : {w_head, 16'h0000};
  assign inst_pc    = r_pc;
  assign fw_ready   = (r_count <= 3'd2);

  assign w_enq   = fw_valid & fw_ready & ~flush;
  assign w_deq   = inst_valid & inst_ready & ~flush;
  assign w_enq_n = !w_enq ? 3'd0 : (r_drop_first ? 3'd1 : 3'd2);
  assign w_deq_n = !w_deq ? 3'd0 : (w_head_is32 ? 3'd2 : 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_q[i] <= 16'h0000;
      r_rd_ptr     <= 2'd0;
      r_wr_ptr     <= 2'd0;
      r_count      <= 3'd0;
      r_drop_first <= 1'b0;
      r_pc         <= 32'h0;
    end else if (flush) begin
      r_rd_ptr     <= 2'd0;
      r_wr_ptr     <= 2'd0;
      r_count      <= 3'd0;
      r_drop_first <= flush_pc[1];
      r_pc         <= {flush_pc[31:1], 1'b0};
    end else begin
      if (w_enq) begin
        // A redirect to an odd halfword keeps only the upper half of the first word
        if (r_drop_first) begin
          r_q[r_wr_ptr] <= fw_data[31:16];
        end else begin
          r_q[r_wr_ptr]         <= fw_data[15:0];
          r_q[r_wr_ptr + 2'd1]  <= fw_data[31:16];
        end
        r_drop_first <= 1'b0;
      end
      r_wr_ptr <= r_wr_ptr + w_enq_n[1:0];
      r_rd_ptr <= r_rd_ptr + w_deq_n[1:0];
      r_count  <= r_count + w_enq_n - w_deq_n;
      r_pc     <= r_pc + {28'd0, w_deq_n, 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_thumb_fetch_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_thumb_fetch_align
// Purpose  : Directed and random checks of thumb_fetch_align against a
//            halfword-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_thumb_fetch_align;

  logic        clk;
  logic        rst_n;
  logic [31:0] fw_data;
  logic        fw_valid;
  logic        fw_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] inst_out;
  logic        inst_is32;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  int n_checks;
  int n_errors;

  // Reference model state
  logic [15:0] m_q[$];
  logic [31:0] m_pc;
  logic        m_drop;

  thumb_fetch_align dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fw_data    (fw_data),
    .fw_valid   (fw_valid),
    .fw_ready   (fw_ready),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .inst_out   (inst_out),
    .inst_is32  (inst_is32),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_is32(input logic [15:0] hw);
    return hw[15:11] inside {5'b11101, 5'b11110, 5'b11111};
  endfunction

  function automatic bit m_valid();
    if (m_q.size() == 0) return 1'b0;
    if (m_is32(m_q[0])) return m_q.size() >= 2;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_out();
    if (m_is32(m_q[0])) return {m_q[0], m_q[1]};
    return {m_q[0], 16'h0000};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc   = 32'h0;
    m_drop = 1'b0;
  endtask

  // Called at posedge+1: apply inputs and move to the sampling point.
  task automatic drive(input logic fv, input logic [31:0] fd, input logic rdy,
                       input logic fl, input logic [31:0] fpc);
    fw_valid   = fv;
    fw_data    = fd;
    inst_ready = rdy;
    flush      = fl;
    flush_pc   = fpc;
    @(negedge clk);
  endtask

  task automatic check_all();
    check("fw_ready", {31'd0, fw_ready}, {31'd0, m_q.size() <= 2});
    check("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid()});
    if (m_valid()) begin
      check("inst_out", inst_out, m_out());
      check("inst_is32", {31'd0, inst_is32}, {31'd0, m_is32(m_q[0])});
      check("inst_pc", inst_pc, m_pc);
    end
  endtask

  // Apply the cycle's handshakes to the model at the clock edge.
  task automatic advance();
    bit deq, enq;
    deq = m_valid() && inst_ready && !flush;
    enq = fw_valid && (m_q.size() <= 2) && !flush;
    @(posedge clk);
    if (flush) begin
      m_q.delete();
      m_pc   = {flush_pc[31:1], 1'b0};
      m_drop = flush_pc[1];
    end else begin
      if (deq) begin
        if (m_is32(m_q[0])) begin
          void'(m_q.pop_front());
          void'(m_q.pop_front());
          m_pc += 32'd4;
        end else begin
          void'(m_q.pop_front());
          m_pc += 32'd2;
        end
      end
      if (enq) begin
        if (m_drop) m_q.push_back(fw_data[31:16]);
        else begin
          m_q.push_back(fw_data[15:0]);
          m_q.push_back(fw_data[31:16]);
        end
        m_drop = 1'b0;
      end
    end
    #1;
  endtask

  task automatic step(input logic fv, input logic [31:0] fd, input logic rdy,
                      input logic fl, input logic [31:0] fpc);
    drive(fv, fd, rdy, fl, fpc);
    check_all();
    advance();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    check({tag, "_is32"},  {31'd0, inst_is32}, 32'd0);
    check({tag, "_out"},   inst_out, 32'h0);
    check({tag, "_pc"},    inst_pc, 32'h0);
    check({tag, "_ready"}, {31'd0, fw_ready}, 32'd1);
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] hw;
    hw = 16'($urandom);
    if ($urandom_range(0, 2) == 0) hw[15:13] = 3'b111;
    return hw;
  endfunction

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    fw_valid   = 1'b0;
    fw_data    = 32'h0;
    flush      = 1'b0;
    flush_pc   = 32'h0;
    inst_ready = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two 16-bit instructions from one word
    step(1'b1, 32'hBF08D001, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("t1_out0", inst_out, 32'hD0010000);
    check_all();
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("t1_out1", inst_out, 32'hBF080000);
    check("t1_pc1", inst_pc, 32'h2);
    check_all();
    advance();

    // 32-bit instruction straddling two words
    step(1'b1, 32'hF0004600, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h0000B800, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("t2_out32", inst_out, 32'hF000B800);
    check("t2_is32", {31'd0, inst_is32}, 32'd1);
    check_all();
    advance();
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Redirect to an odd halfword drops the lower half
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h00000102);
    step(1'b1, 32'hD1FE4770, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("t3_out", inst_out, 32'hD1FE0000);
    check("t3_pc", inst_pc, 32'h102);
    check_all();
    advance();
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Backpressure: only two words fit
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1111_2222 * (i + 1), 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Flush with simultaneous fetch word and dequeue
    step(1'b1, 32'h33334444, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h55556666, 1'b1, 1'b1, 32'h00000200);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("t5_valid", {31'd0, inst_valid}, 32'd0);
    check_all();
    advance();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, {rand_hw(), rand_hw()}, $urandom_range(0, 9) < 7,
           $urandom_range(0, 29) == 0, $urandom & 32'h0000_FFFE);
    end

    // Asynchronous reset with three halfwords buffered
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h00000042);
    step(1'b1, 32'h1234ABCD, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0BAD0C0D, 1'b0, 1'b0, 32'h0);
    check("t6_count3", m_q.size(), 32'd3);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_all();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'hBF08D001, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
